// File: rtl/bsalu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer and its 1-bit slice.
package bsalu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Operation control captured on an accepted start
  typedef struct packed {
    op_e  op;
    logic invert;
  } op_ctrl_t;

  function automatic logic is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: full adder/subtractor cell plus AND/OR with optional inversion.
module alu_bit_slice
  import bsalu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  op_e  op,
  input  logic invert,
  output logic s,
  output logic cout
);

  logic b_eff;

  always_comb begin
    b_eff = b;
    s     = 1'b0;
    cout  = cin;
    case (op)
      OP_ADD, OP_SUB: begin
        // Subtraction is a + ~b with carry-in seeded to 1 by the controller
        b_eff = (op == OP_SUB) ? ~b : b;
        s     = a ^ b_eff ^ cin;
        cout  = (a & b_eff) | (cin & (a ^ b_eff));
      end
      OP_AND: s = (a & b) ^ invert;
      OP_OR:  s = (a | b) ^ invert;
      default: s = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs WIDTH-bit ops LSB first through one alu_bit_slice.
// Optional signed-overflow flag output enabled by defining BSALU_OVERFLOW_EN.
module bit_serial_alu_ctrl
  import bsalu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             invert,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             iszero,
`ifdef BSALU_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             greaterthan
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             nz_q, nz_d;
  logic             gt_q, gt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  op_ctrl_t         ctrl_q, ctrl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             carry_q, carry_d;
  logic             iszero_q, iszero_d;
  logic             gtout_q, gtout_d;
`ifdef BSALU_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic bit_a, bit_b, slice_s, slice_cout, gt_next;

  assign bit_a   = a_q[cnt_q];
  assign bit_b   = b_q[cnt_q];
  // Later (more significant) differing bits overwrite earlier decisions
  assign gt_next = (bit_a != bit_b) ? bit_a : gt_q;

  alu_bit_slice u_slice (
    .a      (bit_a),
    .b      (bit_b),
    .cin    (c_q),
    .op     (ctrl_q.op),
    .invert (ctrl_q.invert),
    .s      (slice_s),
    .cout   (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      nz_q     <= 1'b0;
      gt_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '{op: OP_ADD, invert: 1'b0};
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      iszero_q <= 1'b0;
      gtout_q  <= 1'b0;
`ifdef BSALU_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      nz_q     <= nz_d;
      gt_q     <= gt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
      iszero_q <= iszero_d;
      gtout_q  <= gtout_d;
`ifdef BSALU_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    nz_d     = nz_q;
    gt_d     = gt_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    carry_d  = carry_q;
    iszero_d = iszero_q;
    gtout_d  = gtout_q;
`ifdef BSALU_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          ctrl_d   = '{op: op_e'(op), invert: invert};
          cnt_d    = '0;
          c_d      = (op_e'(op) == OP_SUB);
          gt_d     = 1'b0;
          nz_d     = 1'b0;
          result_d = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        result_d = {slice_s, result_q[WIDTH-1:1]};
        nz_d     = nz_q | slice_s;
        c_d      = slice_cout;
        gt_d     = gt_next;
        if (cnt_q == LAST_BIT) begin
          // Flags load on the last bit so they are valid together with done
          state_d  = ST_FIN;
          done_d   = 1'b1;
          carry_d  = is_arith(ctrl_q.op) ? slice_cout : 1'b0;
          iszero_d = ~(nz_q | slice_s);
          gtout_d  = gt_next;
`ifdef BSALU_OVERFLOW_EN
          ovf_d    = is_arith(ctrl_q.op) ? (c_q ^ slice_cout) : 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign carry_out   = carry_q;
  assign iszero      = iszero_q;
  assign greaterthan = gtout_q;
`ifdef BSALU_OVERFLOW_EN
  assign overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed self-checking bench for bit_serial_alu_ctrl (WIDTH=8).
module tb_bit_serial_alu_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'd0;
  logic             invert = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, carry_out, iszero, greaterthan;
  logic [WIDTH-1:0] result;
`ifdef BSALU_OVERFLOW_EN
  logic             overflow;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  bit_serial_alu_ctrl #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .invert      (invert),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .carry_out   (carry_out),
    .iszero      (iszero),
`ifdef BSALU_OVERFLOW_EN
    .overflow    (overflow),
`endif
    .greaterthan (greaterthan)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Launch one op, scramble inputs after acceptance, observe a bounded window.
  // poke=1 pulses a conflicting start on RUN cycle 3.
  task automatic run_op(input logic [1:0] o, input logic inv,
                        input logic [7:0] av, input logic [7:0] bv, input bit poke,
                        output int lat, output int nbusy, output int ndone);
    a = av; b = bv; op = o; invert = inv; start = 1'b1;
    tick();
    start = 1'b0; a = ~av; b = ~bv; op = o ^ 2'd1; invert = ~inv;
    lat = 0; nbusy = 0; ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) lat = i;
      end
      if (poke && i == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'd1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
  endtask

  task automatic check_flags(input string tag, input logic [7:0] r, input logic c,
                             input logic z, input logic g, input logic v);
    check({tag, ".result"}, 32'(result), 32'(r));
    check({tag, ".carry"}, 32'(carry_out), 32'(c));
    check({tag, ".iszero"}, 32'(iszero), 32'(z));
    check({tag, ".gt"}, 32'(greaterthan), 32'(g));
`ifdef BSALU_OVERFLOW_EN
    check({tag, ".ovf"}, 32'(overflow), 32'(v));
`else
    if (v) begin end
`endif
  endtask

  initial begin
    int lat, nb, nd;
    int done_at[$];

    #12;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check_flags("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // ADD 7F+01: latency and busy width measured here
    run_op(2'd0, 1'b0, 8'h7F, 8'h01, 1'b0, lat, nb, nd);
    check("add.latency", 32'(lat), 32'd9);
    check("add.busy_cycles", 32'(nb), 32'd9);
    check("add.done_count", 32'(nd), 32'd1);
    check_flags("add7f", 8'h80, 1'b0, 1'b0, 1'b1, 1'b1);

    run_op(2'd1, 1'b0, 8'h03, 8'h05, 1'b0, lat, nb, nd);
    check_flags("sub3m5", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);

    run_op(2'd2, 1'b1, 8'hF0, 8'h3C, 1'b0, lat, nb, nd);
    check_flags("nand", 8'hCF, 1'b0, 1'b0, 1'b1, 1'b0);

    run_op(2'd3, 1'b0, 8'h00, 8'h00, 1'b0, lat, nb, nd);
    check_flags("or0", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

    run_op(2'd3, 1'b1, 8'h0F, 8'h30, 1'b0, lat, nb, nd);
    check_flags("nor", 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0);

    // gt must come from the MSB even though lower bits favour b
    run_op(2'd0, 1'b0, 8'h80, 8'h7F, 1'b0, lat, nb, nd);
    check_flags("add80", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);

    run_op(2'd2, 1'b0, 8'hAA, 8'hFF, 1'b0, lat, nb, nd);
    check_flags("and", 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start during RUN is ignored
    run_op(2'd0, 1'b0, 8'h10, 8'h20, 1'b1, lat, nb, nd);
    check("ign.latency", 32'(lat), 32'd9);
    check("ign.done_count", 32'(nd), 32'd1);
    check_flags("ign", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);

    run_op(2'd1, 1'b0, 8'h05, 8'h05, 1'b0, lat, nb, nd);
    check_flags("sub55", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset at RUN cycle 4 clears held flags immediately
    a = 8'h55; b = 8'h0F; op = 2'd0; invert = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check_flags("midrst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    tick(); tick();
    check("postrst.done", 32'(done), 32'd0);

    run_op(2'd0, 1'b0, 8'hFF, 8'h01, 1'b0, lat, nb, nd);
    check("postrst.latency", 32'(lat), 32'd9);
    check_flags("addff", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

    // start held high: done every WIDTH+2 cycles
    a = 8'h01; b = 8'h02; op = 2'd0; invert = 1'b0; start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_at.push_back(i);
    end
    start = 1'b0;
    check("b2b.done_count", 32'(done_at.size()), 32'd4);
    if (done_at.size() >= 3) begin
      check("b2b.spacing1", 32'(done_at[1] - done_at[0]), 32'd10);
      check("b2b.spacing2", 32'(done_at[2] - done_at[1]), 32'd10);
    end else begin
      check("b2b.enough_dones", 32'(done_at.size()), 32'd3);
    end
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    check_flags("b2b", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b.idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
